// File: rtl/mips_pkg.sv
// Shared encodings for the single-cycle MIPS-I subset core.
// Opcode/funct values, ALU operation enum and reset vector.
package mips_pkg;

  localparam logic [31:0] PC_RESET_DEFAULT = 32'h0000_0000;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2A;
  localparam logic [5:0] FN_SLTU = 6'h2B;

  typedef enum logic [3:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_AND,
    ALU_OR,
    ALU_XOR,
    ALU_NOR,
    ALU_SLT,
    ALU_SLTU,
    ALU_SLL,
    ALU_SRL,
    ALU_SRA,
    ALU_LUI
  } alu_op_e;

  function automatic logic [31:0] sext16(input logic [15:0] v);
    return {{16{v[15]}}, v};
  endfunction

endpackage

// File: rtl/mips_regfile.sv
// 32x32 register file: two async read ports, one write port.
// $0 is hardwired to zero; reads see the pre-edge value.
module mips_regfile
  import mips_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        we,
  input  logic [4:0]  waddr,
  input  logic [31:0] wdata,
  input  logic [4:0]  raddr1,
  input  logic [4:0]  raddr2,
  output logic [31:0] rdata1,
  output logic [31:0] rdata2
);

  logic [31:0] regs_q [32];
  logic [31:0] regs_d [32];

  always_comb begin
    regs_d = regs_q;
    if (we && waddr != 5'd0) begin
      regs_d[waddr] = wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      regs_q <= '{default: '0};
    end else begin
      regs_q <= regs_d;
    end
  end

  assign rdata1 = (raddr1 == 5'd0) ? 32'd0 : regs_q[raddr1];
  assign rdata2 = (raddr2 == 5'd0) ? 32'd0 : regs_q[raddr2];

endmodule

// File: rtl/mips_cpu_core.sv
// Single-cycle MIPS-I subset core: decode, ALU and next-PC inline,
// register file in mips_regfile, memories external.
module mips_cpu_core
  import mips_pkg::*;
#(
  parameter logic [31:0] PC_RESET   = PC_RESET_DEFAULT,
  parameter int          DMEM_IDX_W = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [31:0]           instr_in,
  output logic [31:0]           instr_sel,
  output logic [DMEM_IDX_W-1:0] ram_rnum,
  input  logic [31:0]           ram_rdata,
  output logic [DMEM_IDX_W-1:0] ram_wnum,
  output logic [31:0]           ram_wdata,
  output logic                  ram_write,
  output logic                  ram_clock
);

  logic [31:0] pc_q;
  logic [31:0] pc_d;

  logic [5:0]  op;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [4:0]  shamt;
  logic [5:0]  funct;
  logic [15:0] imm;
  logic [25:0] target;

  assign op     = instr_in[31:26];
  assign rs     = instr_in[25:21];
  assign rt     = instr_in[20:16];
  assign rd     = instr_in[15:11];
  assign shamt  = instr_in[10:6];
  assign funct  = instr_in[5:0];
  assign imm    = instr_in[15:0];
  assign target = instr_in[25:0];

  logic [31:0] imm_sext;
  logic [31:0] imm_zext;
  assign imm_sext = sext16(imm);
  assign imm_zext = {16'h0, imm};

  alu_op_e     alu_op;
  logic        use_imm;
  logic        use_zext;
  logic        rf_we;
  logic [4:0]  waddr;
  logic        wb_mem;
  logic        wb_link;
  logic        is_sw;
  logic        is_beq;
  logic        is_bne;
  logic        is_j;
  logic        is_jr;

  always_comb begin
    alu_op   = ALU_ADD;
    use_imm  = 1'b0;
    use_zext = 1'b0;
    rf_we    = 1'b0;
    waddr    = rt;
    wb_mem   = 1'b0;
    wb_link  = 1'b0;
    is_sw    = 1'b0;
    is_beq   = 1'b0;
    is_bne   = 1'b0;
    is_j     = 1'b0;
    is_jr    = 1'b0;
    unique case (op)
      OP_RTYPE: begin
        waddr = rd;
        rf_we = 1'b1;
        unique case (funct)
          FN_ADD, FN_ADDU: alu_op = ALU_ADD;
          FN_SUB, FN_SUBU: alu_op = ALU_SUB;
          FN_AND:  alu_op = ALU_AND;
          FN_OR:   alu_op = ALU_OR;
          FN_XOR:  alu_op = ALU_XOR;
          FN_NOR:  alu_op = ALU_NOR;
          FN_SLT:  alu_op = ALU_SLT;
          FN_SLTU: alu_op = ALU_SLTU;
          FN_SLL:  alu_op = ALU_SLL;
          FN_SRL:  alu_op = ALU_SRL;
          FN_SRA:  alu_op = ALU_SRA;
          FN_JR: begin
            rf_we = 1'b0;
            is_jr = 1'b1;
          end
          default: rf_we = 1'b0;
        endcase
      end
      OP_ADDI, OP_ADDIU: begin
        rf_we   = 1'b1;
        use_imm = 1'b1;
      end
      OP_SLTI: begin
        rf_we   = 1'b1;
        use_imm = 1'b1;
        alu_op  = ALU_SLT;
      end
      OP_SLTIU: begin
        rf_we   = 1'b1;
        use_imm = 1'b1;
        alu_op  = ALU_SLTU;
      end
      OP_ANDI, OP_ORI, OP_XORI: begin
        rf_we    = 1'b1;
        use_imm  = 1'b1;
        use_zext = 1'b1;
        alu_op   = (op == OP_ANDI) ? ALU_AND :
                   (op == OP_ORI)  ? ALU_OR  : ALU_XOR;
      end
      OP_LUI: begin
        rf_we  = 1'b1;
        alu_op = ALU_LUI;
      end
      OP_LW: begin
        rf_we  = 1'b1;
        wb_mem = 1'b1;
      end
      OP_SW:  is_sw  = 1'b1;
      OP_BEQ: is_beq = 1'b1;
      OP_BNE: is_bne = 1'b1;
      OP_J:   is_j   = 1'b1;
      OP_JAL: begin
        is_j    = 1'b1;
        wb_link = 1'b1;
        rf_we   = 1'b1;
        waddr   = 5'd31;
      end
      default: ;
    endcase
  end

  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic [31:0] alu_b;
  logic [31:0] alu_res;
  logic [31:0] rf_wdata;
  logic        rf_wen;
  logic [31:0] pc_plus4;

  always_comb begin
    alu_b   = use_imm ? (use_zext ? imm_zext : imm_sext) : rt_val;
    alu_res = rs_val + alu_b;
    unique case (alu_op)
      ALU_ADD:  alu_res = rs_val + alu_b;
      ALU_SUB:  alu_res = rs_val - alu_b;
      ALU_AND:  alu_res = rs_val & alu_b;
      ALU_OR:   alu_res = rs_val | alu_b;
      ALU_XOR:  alu_res = rs_val ^ alu_b;
      ALU_NOR:  alu_res = ~(rs_val | alu_b);
      ALU_SLT:  alu_res = {31'd0, $signed(rs_val) < $signed(alu_b)};
      ALU_SLTU: alu_res = {31'd0, rs_val < alu_b};
      ALU_SLL:  alu_res = alu_b << shamt;
      ALU_SRL:  alu_res = alu_b >> shamt;
      ALU_SRA:  alu_res = $unsigned($signed(alu_b) >>> shamt);
      ALU_LUI:  alu_res = {imm, 16'h0};
      default:  ;
    endcase
  end

  // Reset gates both architectural side effects on the reset edge.
  assign rf_wen   = rf_we & ~reset;
  assign rf_wdata = wb_mem  ? ram_rdata :
                    wb_link ? pc_plus4  : alu_res;

  mips_regfile u_regfile (
    .clk    (clock),
    .reset  (reset),
    .we     (rf_wen),
    .waddr  (waddr),
    .wdata  (rf_wdata),
    .raddr1 (rs),
    .raddr2 (rt),
    .rdata1 (rs_val),
    .rdata2 (rt_val)
  );

  logic [31:0] ea;
  logic [31:0] br_tgt;
  logic [31:0] jmp_tgt;
  logic        rs_eq_rt;

  assign ea       = rs_val + imm_sext;
  assign pc_plus4 = pc_q + 32'd4;
  assign br_tgt   = pc_plus4 + (imm_sext << 2);
  assign jmp_tgt  = {pc_plus4[31:28], target, 2'b00};
  assign rs_eq_rt = (rs_val == rt_val);

  always_comb begin
    pc_d = pc_plus4;
    unique case (1'b1)
      is_jr: pc_d = rs_val;
      is_j:  pc_d = jmp_tgt;
      (is_beq && rs_eq_rt) || (is_bne && !rs_eq_rt): pc_d = br_tgt;
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      pc_q <= PC_RESET;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign instr_sel = pc_q;
  assign ram_rnum  = DMEM_IDX_W'(ea >> 2);
  assign ram_wnum  = DMEM_IDX_W'(ea >> 2);
  assign ram_wdata = rt_val;
  assign ram_write = is_sw & ~reset;
  assign ram_clock = clock;

endmodule

// File: tb/tb_mips_cpu_core.sv
// Bench for mips_cpu_core: directed programs plus random straight-line
// code, all checked against an instruction-level reference model.
module tb_mips_cpu_core;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] instr_in;
  logic [31:0] instr_sel;
  logic [31:0] ram_rnum;
  logic [31:0] ram_rdata;
  logic [31:0] ram_wnum;
  logic [31:0] ram_wdata;
  logic        ram_write;
  logic        ram_clock;

  logic [31:0] imem [0:255];
  logic [31:0] dmem [0:63];
  logic [31:0] pre  [0:63];
  logic        ld_en = 1'b0;
  logic [5:0]  ld_idx = 6'd0;
  logic [31:0] ld_val = 32'd0;

  logic [31:0] m_r   [0:31];
  logic [31:0] m_mem [0:63];
  logic [31:0] m_pc;

  int checks = 0;
  int errors = 0;

  mips_cpu_core dut (
    .clock     (clock),
    .reset     (reset),
    .instr_in  (instr_in),
    .instr_sel (instr_sel),
    .ram_rnum  (ram_rnum),
    .ram_rdata (ram_rdata),
    .ram_wnum  (ram_wnum),
    .ram_wdata (ram_wdata),
    .ram_write (ram_write),
    .ram_clock (ram_clock)
  );

  always #5 clock = ~clock;

  assign instr_in  = imem[instr_sel[9:2]];
  assign ram_rdata = dmem[ram_rnum[5:0]];

  always @(posedge ram_clock) begin
    if (ram_write) dmem[ram_wnum[5:0]] <= ram_wdata;
    else if (ld_en) dmem[ld_idx] <= ld_val;
  end

  task automatic check_eq(input string tag, input logic [31:0] got,
                          input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] enc_r(int fn, int rd, int rs, int rt,
                                        int sh);
    return {6'h00, rs[4:0], rt[4:0], rd[4:0], sh[4:0], fn[5:0]};
  endfunction

  function automatic logic [31:0] enc_i(int op, int rt, int rs, int imm);
    return {op[5:0], rs[4:0], rt[4:0], imm[15:0]};
  endfunction

  function automatic logic [31:0] enc_j(int op, int tgt);
    return {op[5:0], tgt[25:0]};
  endfunction

  // Architectural model: one call executes one instruction.
  task automatic model_exec(input logic [31:0] ins, output logic we,
                            output logic [31:0] ea, output logic [31:0] wd);
    logic [5:0]  op, fn;
    logic [4:0]  rs, rt, rd, sh, dst;
    logic [31:0] a, b, se, ze, npc, val;
    logic        wr;
    op = ins[31:26]; rs = ins[25:21]; rt = ins[20:16];
    rd = ins[15:11]; sh = ins[10:6];  fn = ins[5:0];
    a = m_r[rs]; b = m_r[rt];
    se = {{16{ins[15]}}, ins[15:0]};
    ze = {16'h0, ins[15:0]};
    npc = m_pc + 32'd4; ea = a + se; wd = b;
    we = 1'b0; wr = 1'b0; dst = rt; val = 32'd0;
    case (op)
      6'h00: begin
        dst = rd; wr = 1'b1;
        case (fn)
          6'h20, 6'h21: val = a + b;
          6'h22, 6'h23: val = a - b;
          6'h24: val = a & b;
          6'h25: val = a | b;
          6'h26: val = a ^ b;
          6'h27: val = ~(a | b);
          6'h2A: val = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
          6'h2B: val = (a < b) ? 32'd1 : 32'd0;
          6'h00: val = b << sh;
          6'h02: val = b >> sh;
          6'h03: val = $signed(b) >>> sh;
          6'h08: begin wr = 1'b0; npc = a; end
          default: wr = 1'b0;
        endcase
      end
      6'h08, 6'h09: begin wr = 1'b1; val = a + se; end
      6'h0A: begin wr = 1'b1; val = ($signed(a) < $signed(se)) ? 1 : 0; end
      6'h0B: begin wr = 1'b1; val = (a < se) ? 32'd1 : 32'd0; end
      6'h0C: begin wr = 1'b1; val = a & ze; end
      6'h0D: begin wr = 1'b1; val = a | ze; end
      6'h0E: begin wr = 1'b1; val = a ^ ze; end
      6'h0F: begin wr = 1'b1; val = {ins[15:0], 16'h0}; end
      6'h23: begin wr = 1'b1; val = m_mem[ea[7:2]]; end
      6'h2B: begin we = 1'b1; m_mem[ea[7:2]] = b; end
      6'h04: if (a == b) npc = m_pc + 32'd4 + (se << 2);
      6'h05: if (a != b) npc = m_pc + 32'd4 + (se << 2);
      6'h02: npc = {npc[31:28], ins[25:0], 2'b00};
      6'h03: begin
        npc = {npc[31:28], ins[25:0], 2'b00};
        wr = 1'b1; dst = 5'd31; val = m_pc + 32'd4;
      end
      default: ;
    endcase
    if (wr && dst != 5'd0) m_r[dst] = val;
    m_pc = npc;
  endtask

  task automatic clear_prog();
    for (int i = 0; i < 256; i++) imem[i] = 32'd0;
    for (int i = 0; i < 64; i++) pre[i] = 32'd0;
  endtask

  // Holds reset while preloading data memory, then releases at a negedge.
  task automatic reset_and_load();
    reset = 1'b1;
    for (int i = 0; i < 64; i++) begin
      ld_en = 1'b1; ld_idx = i[5:0]; ld_val = pre[i];
      m_mem[i] = pre[i];
      @(posedge clock); #1;
      check_eq("rst_we", {31'd0, ram_write}, 32'd0);
    end
    ld_en = 1'b0;
    check_eq("rst_pc", instr_sel, 32'd0);
    for (int i = 0; i < 32; i++) m_r[i] = 32'd0;
    m_pc = 32'd0;
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic step();
    logic        we;
    logic [31:0] ea, wd, pc;
    pc = m_pc;
    check_eq("pc", instr_sel, pc);
    model_exec(imem[pc[9:2]], we, ea, wd);
    check_eq("we", {31'd0, ram_write}, {31'd0, we});
    check_eq("rnum", ram_rnum, ea >> 2);
    if (we) begin
      check_eq("wnum", ram_wnum, ea >> 2);
      check_eq("wdata", ram_wdata, wd);
    end
    @(negedge clock);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic run_until(input logic [31:0] pc, input int budget);
    int n = 0;
    while (m_pc != pc && n < budget) begin
      step();
      n++;
    end
    check_eq("reach_pc", instr_sel, pc);
  endtask

  task automatic check_mem();
    for (int i = 0; i < 64; i++)
      check_eq($sformatf("mem%0d", i), dmem[i], m_mem[i]);
  endtask

  task automatic rand_prog(input int len);
    int fns [13] = '{'h20, 'h21, 'h22, 'h23, 'h24, 'h25, 'h26, 'h27,
                     'h2A, 'h2B, 'h00, 'h02, 'h03};
    int iops [8] = '{'h08, 'h09, 'h0A, 'h0B, 'h0C, 'h0D, 'h0E, 'h0F};
    int bad  [6] = '{'h01, 'h06, 'h07, 'h10, 'h20, 'h3F};
    int k;
    clear_prog();
    for (int i = 0; i < 64; i++) pre[i] = $urandom;
    for (k = 0; k < len; k++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3: imem[k] = enc_r(fns[$urandom_range(0, 12)],
                      $urandom_range(0, 31), $urandom_range(0, 31),
                      $urandom_range(0, 31), $urandom_range(0, 31));
        4, 5, 6: imem[k] = enc_i(iops[$urandom_range(0, 7)],
                      $urandom_range(0, 31), $urandom_range(0, 31),
                      $urandom_range(0, 65535));
        7: imem[k] = enc_i('h2B, $urandom_range(0, 31), 0,
                      $urandom_range(0, 255));
        8: imem[k] = enc_i('h23, $urandom_range(0, 31), 0,
                      $urandom_range(0, 255));
        default: imem[k] = $urandom_range(0, 1) == 1 ?
                      {bad[$urandom_range(0, 5)], 26'($urandom)} :
                      enc_r('h09 + $urandom_range(0, 3),
                            $urandom_range(1, 31), $urandom_range(0, 31),
                            $urandom_range(0, 31), 0);
      endcase
    end
    for (int r = 1; r < 32; r++) imem[k + r - 1] = enc_i('h2B, r, 0, 4 * r);
    reset_and_load();
    run(len + 31);
    check_mem();
  endtask

  initial begin
    // ALU chain
    clear_prog();
    imem[0]  = enc_i('h08, 1, 0, 5);
    imem[1]  = enc_i('h08, 2, 0, -3);
    imem[2]  = enc_r('h20, 3, 1, 2, 0);
    imem[3]  = enc_r('h22, 4, 2, 1, 0);
    imem[4]  = enc_r('h2A, 5, 2, 1, 0);
    imem[5]  = enc_r('h2B, 6, 2, 1, 0);
    imem[6]  = enc_i('h0F, 7, 0, 'h1234);
    imem[7]  = enc_i('h0D, 7, 7, 'h5678);
    for (int r = 3; r < 8; r++) imem[5 + r] = enc_i('h2B, r, 0, 4 * r);
    reset_and_load();
    run(1);
    check_eq("first_pc4", instr_sel, 32'd4);
    run(12);
    check_eq("alu_add", dmem[3], 32'd2);
    check_eq("alu_sub", dmem[4], 32'hFFFF_FFF8);
    check_eq("alu_slt", dmem[5], 32'd1);
    check_eq("alu_sltu", dmem[6], 32'd0);
    check_eq("alu_lui", dmem[7], 32'h1234_5678);

    // Memory
    clear_prog();
    imem[0] = enc_i('h08, 1, 0, 42);
    imem[1] = enc_i('h2B, 1, 0, 8);
    imem[2] = enc_i('h23, 2, 0, 8);
    imem[3] = enc_i('h2B, 2, 0, 12);
    reset_and_load();
    run(1);
    check_eq("st_wnum", ram_wnum, 32'd2);
    check_eq("st_wdata", ram_wdata, 32'd42);
    run(3);
    check_eq("mem_w2", dmem[2], 32'd42);
    check_eq("mem_w3", dmem[3], 32'd42);

    // Loop summing 1..10
    clear_prog();
    imem[0] = enc_i('h08, 1, 0, 0);
    imem[1] = enc_i('h08, 2, 0, 10);
    imem[2] = enc_r('h20, 1, 1, 2, 0);
    imem[3] = enc_i('h08, 2, 2, -1);
    imem[4] = enc_i('h05, 0, 2, -3);
    imem[5] = enc_i('h04, 0, 1, 5);
    imem[6] = enc_i('h2B, 1, 0, 0);
    reset_and_load();
    run_until(32'd20, 100);
    step();
    check_eq("beq_nt", instr_sel, 32'd24);
    step();
    check_eq("loop_sum", dmem[0], 32'd55);

    // JAL / JR
    clear_prog();
    imem[0]  = enc_i('h08, 8, 0, 1);
    imem[1]  = enc_j('h03, 'h10);
    imem[2]  = enc_i('h2B, 31, 0, 0);
    imem[3]  = enc_i('h2B, 8, 0, 4);
    imem[16] = enc_i('h08, 8, 0, 7);
    imem[17] = enc_r('h08, 0, 31, 0, 0);
    reset_and_load();
    run(2);
    check_eq("jal_tgt", instr_sel, 32'h40);
    run(2);
    check_eq("jr_ret", instr_sel, 32'd8);
    run(2);
    check_eq("jal_link", dmem[0], 32'd8);
    check_eq("sub_r8", dmem[1], 32'd7);

    // $0 and reset during a store
    clear_prog();
    pre[0] = 32'hDEAD_0000;
    pre[1] = 32'hBEEF_0001;
    imem[0] = enc_i('h08, 0, 0, 9);
    imem[1] = enc_i('h2B, 0, 0, 0);
    imem[2] = enc_i('h08, 1, 0, 5);
    imem[3] = enc_i('h2B, 1, 0, 4);
    reset_and_load();
    run(2);
    check_eq("zero_reg", dmem[0], 32'd0);
    run_until(32'd12, 10);
    reset = 1'b1;
    #1;
    check_eq("rst_sw_we", {31'd0, ram_write}, 32'd0);
    @(posedge clock); #1;
    check_eq("rst_sw_pc", instr_sel, 32'd0);
    check_eq("rst_sw_mem", dmem[1], 32'hBEEF_0001);
    @(negedge clock);

    for (int t = 0; t < 6; t++) rand_prog(40);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
